// File: rtl/serial_deframer_pkg.sv
// ============================================================================
// serial_deframer_pkg
// Shared types and helpers for the serial deframer: FSM state encoding,
// default sync pattern and counter width helper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_deframer_pkg;

    // Deframer top-level states
    typedef enum logic [0:0] {
        HUNT    = 1'b0,
        PAYLOAD = 1'b1
    } deframer_state_t;

    // Default sync pattern, MSB first on the wire
    localparam logic [7:0] c_sync_default = 8'b0111_0011;

    // Width of a counter that must hold the values 0..n-1 (at least one bit)
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_deframer_if.sv
// ============================================================================
// serial_deframer_if
// Parallel word output of the deframer: valid/ready word port plus the
// frame status pulses. Option: SERIAL_DEFRAMER_PARITY_EN adds parity_err.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_deframer_if #(
    parameter int WORD_W = 8
);

    logic [WORD_W-1:0] word_o;
    logic              word_valid;
    logic              word_ready;
    logic              frame_start;
    logic              overflow;
    logic              in_frame;
`ifdef SERIAL_DEFRAMER_PARITY_EN
    logic              parity_err;
`endif

    // Deframer side
    modport master (
`ifdef SERIAL_DEFRAMER_PARITY_EN
        output parity_err,
`endif
        output word_o, word_valid, frame_start, overflow, in_frame,
        input  word_ready
    );

    // Downstream consumer side
    modport slave (
`ifdef SERIAL_DEFRAMER_PARITY_EN
        input  parity_err,
`endif
        input  word_o, word_valid, frame_start, overflow, in_frame,
        output word_ready
    );

endinterface

`default_nettype wire

// File: rtl/serial_deframer_sync_hunter.sv
// ============================================================================
// sync_hunter
// SYNC_W-bit serial history with equality compare against the sync pattern.
// match is registered: it is high in the cycle after the edge that sampled
// the final sync bit. A match needs SYNC_W bits sampled since reset/clear,
// so a zeroed history can never complete a pattern early.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_hunter
    import serial_deframer_pkg::*;
#(
    parameter int              SYNC_W = 8,
    parameter logic [SYNC_W-1:0] SYNC = c_sync_default
) (
    input  logic clk,
    input  logic rst,
    input  logic sdin,
    input  logic enable,
    input  logic clear,
    output logic match
);

    localparam int                 c_cnt_w = cnt_w(SYNC_W + 1);
    localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(SYNC_W);
    localparam logic [c_cnt_w-1:0] c_need  = c_cnt_w'(SYNC_W - 1);

    logic [SYNC_W-1:0]  r_hist;
    logic [c_cnt_w-1:0] r_seen;
    logic [SYNC_W-1:0]  w_hist_next;

    // History including the bit sampled on this edge
    assign w_hist_next = {r_hist[SYNC_W-2:0], sdin};

    // Shift history, count sampled bits (saturating) and register the compare
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hist <= '0;
            r_seen <= '0;
            match  <= 1'b0;
        end else if (clear) begin
            r_hist <= '0;
            r_seen <= '0;
            match  <= 1'b0;
        end else if (enable) begin
            r_hist <= w_hist_next;
            if (r_seen != c_full) begin
                r_seen <= r_seen + c_cnt_w'(1);
            end
            match <= (w_hist_next == SYNC) && (r_seen >= c_need);
        end else begin
            match <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/serial_deframer.sv
// ============================================================================
// serial_deframer
// Hunts a serial stream for a sync pattern, then slices WORDS_PER_FRAME
// words of WORD_W bits (first bit at MSB) and offers them on a valid/ready
// port. A word completing while an unaccepted word is held is dropped and
// flagged with an overflow pulse.
// Option: SERIAL_DEFRAMER_PARITY_EN - each word is followed by an even
// parity bit; parity_err reports XOR(word, parity) for the held word.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_deframer
    import serial_deframer_pkg::*;
#(
    parameter int                WORD_W          = 8,
    parameter int                SYNC_W          = 8,
    parameter logic [SYNC_W-1:0] SYNC            = c_sync_default,
    parameter int                WORDS_PER_FRAME = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sdin,
    serial_deframer_if.master bus
);

`ifdef SERIAL_DEFRAMER_PARITY_EN
    localparam int c_last_bit = WORD_W;
`else
    localparam int c_last_bit = WORD_W - 1;
`endif
    localparam int                   c_bit_cw    = cnt_w(c_last_bit + 1);
    localparam int                   c_word_cw   = cnt_w(WORDS_PER_FRAME);
    localparam logic [c_bit_cw-1:0]  c_bit_last  = c_bit_cw'(c_last_bit);
    localparam logic [c_word_cw-1:0] c_word_last = c_word_cw'(WORDS_PER_FRAME - 1);

    deframer_state_t      r_state;
    deframer_state_t      w_state_nxt;
    logic [c_bit_cw-1:0]  r_bit_cnt;
    logic [c_word_cw-1:0] r_word_cnt;
    logic [WORD_W-1:0]    r_word;
    logic                 r_valid;
    logic                 r_overflow;
    logic                 w_match;
    logic                 w_shift;
    logic                 w_complete;
    logic                 w_frame_done;
    logic                 w_accept;
    logic [WORD_W-1:0]    w_word_new;
    logic                 w_par_new;

    // The hunter's match cycle is the first payload cycle: the bit sampled on
    // the edge ending it is payload bit 0, so the datapath runs on match too.
    assign w_shift      = w_match || (r_state == PAYLOAD);
    assign w_complete   = w_shift && (r_bit_cnt == c_bit_last);
    assign w_frame_done = w_complete && (r_word_cnt == c_word_last);
    assign w_accept     = r_valid && bus.word_ready;

    sync_hunter #(
        .SYNC_W (SYNC_W),
        .SYNC   (SYNC)
    ) u_sync_hunter (
        .clk    (clk),
        .rst    (rst),
        .sdin   (sdin),
        .enable ((r_state == HUNT) && !w_match),
        .clear  (w_frame_done),
        .match  (w_match)
    );

`ifdef SERIAL_DEFRAMER_PARITY_EN
    logic [WORD_W-1:0] r_shift;
    logic              r_parity_err;

    assign w_word_new = r_shift;
    assign w_par_new  = ^{r_shift, sdin};

    // Data bits shift in; the parity bit on the completion edge does not
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift <= '0;
        end else if (w_shift && !w_complete) begin
            r_shift <= {r_shift[WORD_W-2:0], sdin};
        end
    end

    // Parity flag is captured together with the word it describes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_parity_err <= 1'b0;
        end else if (w_complete && (!r_valid || bus.word_ready)) begin
            r_parity_err <= w_par_new;
        end
    end

    assign bus.parity_err = r_parity_err;
`else
    logic [WORD_W-2:0] r_shift;

    assign w_word_new = {r_shift, sdin};
    assign w_par_new  = 1'b0;

    // Keep the first WORD_W-1 bits; the completing bit joins combinationally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift <= '0;
        end else if (w_shift) begin
            r_shift <= w_word_new[WORD_W-2:0];
        end
    end
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: enter payload on a sync, leave after the last word
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            HUNT:    if (w_match)      w_state_nxt = PAYLOAD;
            PAYLOAD: if (w_frame_done) w_state_nxt = HUNT;
            default: w_state_nxt = HUNT;
        endcase
    end

    // Bit and word counters; both idle at zero outside a frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
        end else begin
            if (w_complete) begin
                r_bit_cnt <= '0;
            end else if (w_shift) begin
                r_bit_cnt <= r_bit_cnt + c_bit_cw'(1);
            end
            if (w_frame_done) begin
                r_word_cnt <= '0;
            end else if (w_complete) begin
                r_word_cnt <= r_word_cnt + c_word_cw'(1);
            end
        end
    end

    // Output handshake: load on free/accepted slot, otherwise drop and flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word     <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_complete) begin
            if (!r_valid || bus.word_ready) begin
                r_word     <= w_word_new;
                r_valid    <= 1'b1;
                r_overflow <= 1'b0;
            end else begin
                r_overflow <= 1'b1;
            end
        end else begin
            r_overflow <= 1'b0;
            if (w_accept) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.word_o      = r_word;
    assign bus.word_valid  = r_valid;
    assign bus.overflow    = r_overflow;
    assign bus.frame_start = w_match;
    assign bus.in_frame    = w_match || (r_state == PAYLOAD);

endmodule

`default_nettype wire

// File: tb/tb_serial_deframer.sv
// ============================================================================
// tb_serial_deframer
// Self-checking bench: directed frames plus randomized frames and ready
// patterns, compared each cycle against a bit-stream reference model.
// Option: SERIAL_DEFRAMER_PARITY_EN adds parity bits and parity_err checks.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_serial_deframer;

    localparam int         WORD_W = 8;
    localparam int         SYNC_W = 8;
    localparam int         WPF    = 4;
    localparam logic [7:0] SYNC   = 8'b0111_0011;
`ifdef SERIAL_DEFRAMER_PARITY_EN
    localparam int         PERIOD = WORD_W + 1;
`else
    localparam int         PERIOD = WORD_W;
`endif

    logic clk  = 1'b0;
    logic rst  = 1'b0;
    logic sdin = 1'b0;

    serial_deframer_if #(.WORD_W(WORD_W)) bus ();

    serial_deframer #(
        .WORD_W          (WORD_W),
        .SYNC_W          (SYNC_W),
        .SYNC            (SYNC),
        .WORDS_PER_FRAME (WPF)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .sdin (sdin),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus queues: one serial bit and one ready value per clock edge
    bit q_bits[$];
    bit q_rdy[$];
    bit cur_rdy;

    // Reference model state (stream view and output slot)
    bit         m_hunt;
    logic [7:0] m_hist;
    int         m_seen;
    int         m_pos;
    int         m_wcnt;
    logic [7:0] m_acc;
    bit         m_valid;
    logic [7:0] m_word;
    bit         m_perr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_bit(input bit b);
        q_bits.push_back(b);
        q_rdy.push_back(cur_rdy);
    endtask

    task automatic push_bits(input logic [7:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) push_bit(v[i]);
    endtask

    task automatic push_word(input logic [7:0] w, input bit bad);
        push_bits(w, 8);
`ifdef SERIAL_DEFRAMER_PARITY_EN
        push_bit((^w) ^ bad);
`else
        if (bad) begin end
`endif
    endtask

    task automatic model_reset();
        m_hunt  = 1'b1;
        m_hist  = '0;
        m_seen  = 0;
        m_pos   = 0;
        m_wcnt  = 0;
        m_acc   = '0;
        m_valid = 1'b0;
        m_word  = '0;
        m_perr  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".word_o"},      32'(bus.word_o),      32'd0);
        check({tag, ".word_valid"},  32'(bus.word_valid),  32'd0);
        check({tag, ".frame_start"}, 32'(bus.frame_start), 32'd0);
        check({tag, ".overflow"},    32'(bus.overflow),    32'd0);
        check({tag, ".in_frame"},    32'(bus.in_frame),    32'd0);
`ifdef SERIAL_DEFRAMER_PARITY_EN
        check({tag, ".parity_err"},  32'(bus.parity_err),  32'd0);
`endif
    endtask

    // Hold reset low for 4 cycles with sdin toggling
    task automatic do_reset();
        #1;
        rst = 1'b0;
        bus.word_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sdin = i[0];
            @(posedge clk);
            #1;
            check_all_zero("reset");
        end
        rst = 1'b1;
        model_reset();
    endtask

    // Play the queued stream, stepping the model once per edge
    task automatic run_stream();
        bit         b;
        bit         r;
        bit         e_fs;
        bit         e_ovf;
        bit         done;
        logic [7:0] nw;
        bit         np;
        for (int t = 0; t < q_bits.size(); t++) begin
            b = q_bits[t];
            r = q_rdy[t];
            sdin = b;
            bus.word_ready = r;
            @(posedge clk);
            #1;
            e_fs  = 1'b0;
            e_ovf = 1'b0;
            done  = 1'b0;
            nw    = '0;
            np    = 1'b0;
            if (m_hunt) begin
                m_hist = {m_hist[6:0], b};
                if (m_seen < SYNC_W) m_seen++;
                if (m_seen == SYNC_W && m_hist == SYNC) begin
                    e_fs   = 1'b1;
                    m_hunt = 1'b0;
                    m_pos  = 0;
                    m_wcnt = 0;
                end
            end else begin
                m_pos++;
                if (m_pos <= WORD_W) m_acc = {m_acc[6:0], b};
                if (m_pos == PERIOD) begin
                    done = 1'b1;
                    nw   = m_acc;
`ifdef SERIAL_DEFRAMER_PARITY_EN
                    np   = (^m_acc) ^ b;
`endif
                    m_pos = 0;
                    m_wcnt++;
                    if (m_wcnt == WPF) begin
                        m_hunt = 1'b1;
                        m_hist = '0;
                        m_seen = 0;
                    end
                end
            end
            if (done) begin
                if (!m_valid || r) begin
                    m_word  = nw;
                    m_perr  = np;
                    m_valid = 1'b1;
                end else begin
                    e_ovf = 1'b1;
                end
            end else if (m_valid && r) begin
                m_valid = 1'b0;
            end
            check("frame_start", 32'(bus.frame_start), 32'(e_fs));
            check("in_frame",    32'(bus.in_frame),    32'(!m_hunt));
            check("word_valid",  32'(bus.word_valid),  32'(m_valid));
            check("overflow",    32'(bus.overflow),    32'(e_ovf));
            check("word_o",      32'(bus.word_o),      32'(m_word));
`ifdef SERIAL_DEFRAMER_PARITY_EN
            if (m_valid) check("parity_err", 32'(bus.parity_err), 32'(m_perr));
`endif
        end
        q_bits.delete();
        q_rdy.delete();
    endtask

    initial begin
        bus.word_ready = 1'b0;
        model_reset();
        do_reset();

        // Seven sync-tail bits right after reset must not form a sync
        cur_rdy = 1'b1;
        push_bits(SYNC, 7);
        // Basic frame
        push_bits(SYNC, 8);
        push_word(8'hA5, 1'b0); push_word(8'h3C, 1'b0);
        push_word(8'hFF, 1'b0); push_word(8'h00, 1'b0);
        push_bits(8'h00, 4);
        // Overlap prefix and sync-valued payload
        push_bit(1'b0); push_bits(SYNC, 8);
        for (int i = 0; i < 4; i++) push_word(8'h73, 1'b0);
        push_bits(8'h00, 4);
        // Full backpressure, then drain
        cur_rdy = 1'b0;
        push_bits(SYNC, 8);
        push_word(8'hA5, 1'b0); push_word(8'h3C, 1'b0);
        push_word(8'hFF, 1'b0); push_word(8'h00, 1'b0);
        cur_rdy = 1'b1;
        push_bits(8'h00, 4);
        // Ready only on the edge completing the second word
        cur_rdy = 1'b0;
        push_bits(SYNC, 8);
        push_word(8'h5A, 1'b0);
        push_word(8'hC3, 1'b0);
        q_rdy[q_rdy.size() - 1] = 1'b1;
        push_word(8'h96, 1'b0); push_word(8'h69, 1'b0);
        cur_rdy = 1'b1;
        push_bits(8'h00, 4);
        run_stream();

        // Randomized frames, gaps and ready patterns
        for (int f = 0; f < 8; f++) begin
            int gap;
            gap = int'($urandom_range(0, 10));
            for (int g = 0; g < gap; g++) push_bit(1'($urandom));
            push_bits(SYNC, 8);
            for (int w = 0; w < WPF; w++) push_word(8'($urandom), $urandom_range(0, 3) == 0);
            for (int k = 0; k < q_rdy.size(); k++)
                q_rdy[k] = ($urandom_range(0, 7) < ((f % 2 == 0) ? 6 : 1));
            run_stream();
        end

        // Reset after 12 payload bits, then a clean frame
        cur_rdy = 1'b1;
        push_bits(SYNC, 8);
        push_bits(8'hA5, 8);
        push_bits(8'h0C, 4);
        run_stream();
        do_reset();
        push_bits(SYNC, 8);
        push_word(8'h11, 1'b0); push_word(8'h22, 1'b1);
        push_word(8'h33, 1'b0); push_word(8'h44, 1'b0);
        push_bits(8'h00, 4);
        run_stream();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
